// File: rtl/mlsd_ctrl_pkg.sv
// Shared constants and types for the MLSD estimate controller.
// Defaults match the flat_mlsd datapath configuration.
package mlsd_ctrl_pkg;

  localparam int NUM_CHANNELS = 32;
  localparam int EST_BITWIDTH = 8;
  localparam int EST_DEPTH    = 11;
  localparam int PIPE_LATENCY = 4;

  localparam int CHAN_W = $clog2(NUM_CHANNELS);
  localparam int TAP_W  = $clog2(EST_DEPTH);

  typedef logic signed [EST_BITWIDTH-1:0] est_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } mlsd_state_e;

  // Index width that stays legal for single-entry dimensions.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/est_bank_regs.sv
// Shadow/active channel-estimate storage with serial tap writes and atomic commit.
// Writes land at the handshake edge; commit copies shadow (including same-cycle write) to active.
module est_bank_regs
  import mlsd_ctrl_pkg::*;
#(
  parameter int numChannels = NUM_CHANNELS,
  parameter int estDepth    = EST_DEPTH,
  parameter int estBitwidth = EST_BITWIDTH,
  localparam int ChanW      = idx_w(numChannels),
  localparam int TapW       = idx_w(estDepth)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_vld_i,
  output logic                   wr_rdy_o,
  input  logic [ChanW-1:0]       wr_chan_i,
  input  logic [TapW-1:0]        wr_tap_i,
  input  logic [estBitwidth-1:0] wr_dat_i,
  input  logic                   commit_i,
  output logic signed [numChannels-1:0][estDepth-1:0][estBitwidth-1:0] active_o,
  output logic                   err_o
);

  logic [numChannels-1:0][estDepth-1:0][estBitwidth-1:0] shadow_q, shadow_d;
  logic [numChannels-1:0][estDepth-1:0][estBitwidth-1:0] active_q, active_d;
  logic rdy_q;
  logic err_q, err_d;
  logic wr_hs, in_range, wr_en, bad_wr;

  assign wr_hs    = wr_vld_i & rdy_q;
  assign in_range = (int'(wr_chan_i) < numChannels) && (int'(wr_tap_i) < estDepth);
  assign wr_en    = wr_hs & in_range;
  assign bad_wr   = wr_hs & ~in_range;

  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) begin
      shadow_d[wr_chan_i][wr_tap_i] = wr_dat_i;
    end
  end

  // Copy from shadow_d so a write in the commit cycle is part of the swap.
  always_comb begin
    active_d = active_q;
    if (commit_i) begin
      active_d = shadow_d;
    end
  end

  // A fresh bad write outranks the clear from a coincident commit.
  always_comb begin
    err_d = err_q;
    if (bad_wr) begin
      err_d = 1'b1;
    end else if (commit_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      rdy_q    <= ~commit_i;
      err_q    <= err_d;
    end
  end

  assign active_o = active_q;
  assign wr_rdy_o = rdy_q;
  assign err_o    = err_q;

endmodule

// File: rtl/mlsd_est_ctrl.sv
// Run-time sequencer for flat_mlsd: estimate bank control, enable gating and warm-up tracking.
// out_valid rises pipeLatency cycles after mlsd_en rises or after any commit while enabled.
module mlsd_est_ctrl
  import mlsd_ctrl_pkg::*;
#(
  parameter int numChannels = NUM_CHANNELS,
  parameter int estBitwidth = EST_BITWIDTH,
  parameter int estDepth    = EST_DEPTH,
  parameter int pipeLatency = PIPE_LATENCY,
  localparam int ChanW      = idx_w(numChannels),
  localparam int TapW       = idx_w(estDepth)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [ChanW-1:0]       cfg_chan,
  input  logic [TapW-1:0]        cfg_tap,
  input  logic [estBitwidth-1:0] cfg_data,
  input  logic                   cfg_commit,
  output logic signed [numChannels-1:0][estDepth-1:0][estBitwidth-1:0] channel_est,
  output logic                   mlsd_en,
  output logic                   out_valid,
  output logic                   cfg_err,
  output logic                   busy
);

  localparam int CntW = idx_w(pipeLatency);
  localparam logic [CntW-1:0] CntLast = CntW'(pipeLatency - 1);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_WARMUP = ST_WARMUP;
  localparam logic [1:0] S_RUN    = ST_RUN;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            en_q, vld_q, busy_q;

  est_bank_regs #(
    .numChannels (numChannels),
    .estDepth    (estDepth),
    .estBitwidth (estBitwidth)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_vld_i  (cfg_valid),
    .wr_rdy_o  (cfg_ready),
    .wr_chan_i (cfg_chan),
    .wr_tap_i  (cfg_tap),
    .wr_dat_i  (cfg_data),
    .commit_i  (cfg_commit),
    .active_o  (channel_est),
    .err_o     (cfg_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_WARMUP;
          cnt_d   = '0;
        end
      end
      S_WARMUP: begin
        if (cnt_q == CntLast) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // stop beats a coincident commit; a commit restarts warm-up on the new taps.
    if (state_q != S_IDLE) begin
      if (stop) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else if (cfg_commit) begin
        state_d = S_WARMUP;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= (state_d != S_IDLE);
      vld_q   <= (state_d == S_RUN);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign mlsd_en   = en_q;
  assign out_valid = vld_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mlsd_est_ctrl.sv
// Self-checking bench for mlsd_est_ctrl: directed table, corner sequences and random run vs a model.
module tb_mlsd_est_ctrl;

  localparam int NCH = 32;
  localparam int DEP = 11;
  localparam int BW  = 8;
  localparam int PL  = 4;

  logic clk = 1'b0;
  logic rst, start, stop, cfg_valid, cfg_commit;
  logic [4:0]    cfg_chan;
  logic [3:0]    cfg_tap;
  logic [BW-1:0] cfg_data;
  logic          cfg_ready, mlsd_en, out_valid, cfg_err, busy;
  logic [NCH-1:0][DEP-1:0][BW-1:0] est;

  int checks = 0;
  int errors = 0;

  // Reference model: bank contents as plain integers, enable flag plus cycles since (re)start.
  int sh[NCH][DEP];
  int ac[NCH][DEP];
  bit m_en, m_err, m_rdy;
  int m_age;

  typedef struct {
    logic st, sp, v;
    int   ch, tp, d;
    logic cm;
    logic en, ov, rdy, err;
  } vec_t;
  vec_t tbl[19];

  mlsd_est_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_chan    (cfg_chan),
    .cfg_tap     (cfg_tap),
    .cfg_data    (cfg_data),
    .cfg_commit  (cfg_commit),
    .channel_est (est),
    .mlsd_en     (mlsd_en),
    .out_valid   (out_valid),
    .cfg_err     (cfg_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_bank(input string nm);
    int bad = 0;
    int bc = 0, bt = 0;
    for (int c = 0; c < NCH; c++)
      for (int t = 0; t < DEP; t++)
        if (est[c][t] !== 8'(ac[c][t])) begin
          if (bad == 0) begin bc = c; bt = t; end
          bad++;
        end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d taps differ, first [%0d][%0d] got %0h expected %0h",
               nm, bad, bc, bt, est[bc][bt], 8'(ac[bc][bt]));
    end
  endtask

  task automatic model_edge();
    bit acc, inr;
    if (rst) begin
      for (int c = 0; c < NCH; c++)
        for (int t = 0; t < DEP; t++) begin
          sh[c][t] = 0;
          ac[c][t] = 0;
        end
      m_en = 0; m_age = 0; m_err = 0; m_rdy = 0;
    end else begin
      acc = cfg_valid && m_rdy;
      inr = (int'(cfg_chan) < NCH) && (int'(cfg_tap) < DEP);
      if (acc && inr) sh[cfg_chan][cfg_tap] = int'($signed(cfg_data));
      if (cfg_commit) ac = sh;
      if (acc && !inr) m_err = 1;
      else if (cfg_commit) m_err = 0;
      m_rdy = !cfg_commit;
      if (m_en && stop) m_en = 0;
      else if (m_en && cfg_commit) m_age = 0;
      else if (m_en) m_age++;
      else if (start && !stop) begin m_en = 1; m_age = 0; end
    end
  endtask

  task automatic compare_model();
    chk("mlsd_en", 32'(mlsd_en), 32'(m_en));
    chk("out_valid", 32'(out_valid), 32'(m_en && (m_age >= PL)));
    chk("busy", 32'(busy), 32'(m_en));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_rdy));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
    chk_bank("bank");
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic set_idle();
    rst = 0; start = 0; stop = 0; cfg_valid = 0; cfg_commit = 0;
    cfg_chan = '0; cfg_tap = '0; cfg_data = '0;
  endtask

  task automatic wr(input int ch, input int tp, input int d);
    set_idle();
    cfg_valid = 1; cfg_chan = 5'(ch); cfg_tap = 4'(tp); cfg_data = 8'(d);
  endtask

  initial begin
    // Directed control table, applied from IDLE with an empty error flag.
    //          st sp v  ch tp d  cm  en ov rdy err
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 0, 0,  1, 1, 1, 0};
    tbl[6]  = '{0, 0, 1, 0, 1, 9, 1,  1, 0, 0, 0};
    tbl[7]  = '{0, 0, 1, 0, 2, 3, 0,  1, 0, 1, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 0};
    tbl[11] = '{0, 0, 1, 0, 11, 5, 0, 1, 1, 1, 1};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 1};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0};
    tbl[14] = '{0, 1, 0, 0, 0, 0, 0,  0, 0, 1, 0};
    tbl[15] = '{1, 1, 0, 0, 0, 0, 0,  0, 0, 1, 0};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0};
    tbl[17] = '{1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0};
    tbl[18] = '{0, 1, 0, 0, 0, 0, 0,  0, 0, 1, 0};

    set_idle();
    rst = 1;
    step();
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    step();
    set_idle();
    for (int i = 0; i < 5; i++) step();
    begin
      int nz = 0;
      for (int c = 0; c < NCH; c++)
        for (int t = 0; t < DEP; t++)
          if (est[c][t] !== '0) nz++;
      chk("idle_est_zero", 32'(nz), 32'd0);
    end
    chk("idle_en", 32'(mlsd_en), 32'd0);
    chk("idle_ov", 32'(out_valid), 32'd0);
    chk("idle_ready", 32'(cfg_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // Shadow writes stay invisible until the commit.
    wr(3, 0, -5);
    step();
    chk("pre_commit_3_0", 32'(est[3][0]), 32'd0);
    wr(31, 10, 7);
    step();
    chk("pre_commit_31_10", 32'(est[31][10]), 32'd0);
    set_idle();
    cfg_commit = 1;
    step();
    chk("commit_3_0", 32'(est[3][0]), 32'h0000_00FB);
    chk("commit_31_10", 32'(est[31][10]), 32'd7);
    chk("commit_ready_low", 32'(cfg_ready), 32'd0);
    set_idle();
    step();
    chk("ready_back", 32'(cfg_ready), 32'd1);

    for (int i = 0; i < 19; i++) begin
      set_idle();
      start = tbl[i].st; stop = tbl[i].sp; cfg_valid = tbl[i].v;
      cfg_chan = 5'(tbl[i].ch); cfg_tap = 4'(tbl[i].tp); cfg_data = 8'(tbl[i].d);
      cfg_commit = tbl[i].cm;
      step();
      chk($sformatf("tbl%0d_en", i), 32'(mlsd_en), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_ov", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_rdy", i), 32'(cfg_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_err", i), 32'(cfg_err), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].en));
    end
    chk("run_commit_0_1", 32'(est[0][1]), 32'd9);
    chk("copy_cycle_drop_0_2", 32'(est[0][2]), 32'd0);
    chk("keep_3_0", 32'(est[3][0]), 32'h0000_00FB);

    // Reset while running returns everything to power-on values.
    set_idle();
    start = 1;
    step();
    set_idle();
    for (int i = 0; i < 6; i++) step();
    chk("run_before_rst", 32'(out_valid), 32'd1);
    rst = 1;
    step();
    chk("rst_run_en", 32'(mlsd_en), 32'd0);
    chk("rst_run_ov", 32'(out_valid), 32'd0);
    chk("rst_run_busy", 32'(busy), 32'd0);
    chk("rst_run_ready", 32'(cfg_ready), 32'd0);
    chk("rst_run_3_0", 32'(est[3][0]), 32'd0);
    chk("rst_run_0_1", 32'(est[0][1]), 32'd0);
    set_idle();
    step();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      set_idle();
      rst        = ($urandom_range(0, 199) == 0);
      start      = ($urandom_range(0, 19) == 0);
      stop       = ($urandom_range(0, 39) == 0);
      cfg_commit = ($urandom_range(0, 14) == 0);
      cfg_valid  = $urandom_range(0, 1);
      cfg_chan   = 5'($urandom);
      cfg_tap    = 4'($urandom_range(0, 15));
      cfg_data   = 8'($urandom);
      if (cfg_commit && int'(cfg_tap) >= DEP) cfg_tap = 4'(int'(cfg_tap) % DEP);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
